// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sp_ram request/grant/rvalid port between several masters.
// An owner FIFO remembers who issued each accepted transfer so responses are routed back in order.
module mem_port_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_MASTERS-1:0]          m_req_i,
    input  logic [N_MASTERS-1:0]          m_we_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_be_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    output logic [N_MASTERS-1:0]          m_gnt_o,
    output logic [N_MASTERS-1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic                          s_req_o,
    output logic                          s_we_o,
    output logic [DATA_W/8-1:0]           s_be_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    input  logic                          s_gnt_i,
    input  logic                          s_rvalid_i,
    input  logic [DATA_W-1:0]             s_rdata_i,
    output logic                          err_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             err_reg;
    logic [IDX_W-1:0] owner_mem [MAX_OUTST];

    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] head_idx;
    logic             win_found;
    logic             fifo_empty;
    logic             fifo_full;
    logic             accept_ok;
    logic             accept;
    logic             pop;

    logic [BE_W-1:0]   be_arr    [N_MASTERS];
    logic [ADDR_W-1:0] addr_arr  [N_MASTERS];
    logic [DATA_W-1:0] wdata_arr [N_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign be_arr[gi]     = m_be_i[gi*BE_W +: BE_W];
            assign addr_arr[gi]   = m_addr_i[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]  = m_wdata_i[gi*DATA_W +: DATA_W];
            assign m_gnt_o[gi]    = accept && (win_idx == IDX_W'(gi));
            assign m_rvalid_o[gi] = pop && (head_idx == IDX_W'(gi));
        end
    endgenerate

    // Scan ptr, ptr+1, ... and take the first requester; win_idx stays 0 when nobody requests.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < N_MASTERS; off++) begin
            idx = (int'(ptr_reg) + off) % N_MASTERS;
            if (!win_found && m_req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    assign fifo_empty = (cnt_reg == '0);
    assign fifo_full  = (cnt_reg == CNT_W'(MAX_OUTST));
    // A response in this cycle frees a slot, so a full FIFO can still accept.
    assign accept_ok  = !fifo_full || s_rvalid_i;
    assign s_req_o    = rst_ni && win_found && accept_ok;
    assign accept     = s_req_o && s_gnt_i;
    assign pop        = rst_ni && s_rvalid_i && !fifo_empty;
    assign head_idx   = owner_mem[rd_ptr_reg];

    assign s_we_o     = m_we_i[win_idx];
    assign s_be_o     = be_arr[win_idx];
    assign s_addr_o   = addr_arr[win_idx];
    assign s_wdata_o  = wdata_arr[win_idx];
    assign m_rdata_o  = s_rdata_i;
    assign err_o      = err_reg;

    always_comb begin
        ptr_next    = ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (accept) begin
            ptr_next    = (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
            wr_ptr_next = (wr_ptr_reg == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (s_rvalid_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Owner storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            owner_mem[wr_ptr_reg] <= win_idx;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses into a scoreboard,
// an independent monitor pops and compares whenever any m_rvalid_o bit is high.
module tb_mem_port_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  m_req, m_we, m_gnt, m_rvalid;
    logic [N*DW/8-1:0] m_be;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          s_req, s_we, s_gnt, s_rvalid, err;
    logic [DW/8-1:0] s_be;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    int tests = 0;
    int fails = 0;
    int seq [N];
    logic [31:0] ram_q [$];
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .err_o(err)
    );

    function automatic logic [31:0] addr_of(input int k);
        return 32'(32'h1000 * (k + 1) + seq[k] * 4);
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fields();
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW]  = addr_of(k);
            m_wdata[k*DW +: DW] = ~addr_of(k);
            m_we[k]             = (k == 1);
            m_be[k*4 +: 4]      = (k == 1) ? 4'h3 : 4'hF;
        end
    endtask

    // One clock cycle: drive at the falling edge, check combinational outputs 1 ns later.
    task automatic cyc(input string tag, input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [1:0] exp_gnt, input logic exp_sreq);
        int  w;
        logic spurious;
        m_req    = req;
        drive_fields();
        s_gnt    = gnt;
        s_rvalid = rv;
        spurious = rv && (ram_q.size() == 0);
        if (rv && !spurious) s_rdata = ram_q.pop_front();
        else                 s_rdata = 32'hDEAD_BEEF;
        #1;
        check({tag, " s_req"}, 32'(s_req), 32'(exp_sreq));
        check({tag, " gnt"}, 32'(m_gnt), 32'(exp_gnt));
        if (spurious) check({tag, " spurious rvalid"}, 32'(m_rvalid), 32'h0);
        if (exp_gnt != 2'b00) begin
            w = exp_gnt[1] ? 1 : 0;
            check({tag, " s_addr"}, s_addr, addr_of(w));
            check({tag, " s_we"}, 32'(s_we), (w == 1) ? 32'h1 : 32'h0);
            ram_q.push_back(data_of(addr_of(w)));
            exp_q.push_back({exp_gnt, data_of(addr_of(w))});
            $display("[TB] %s: accept m%0d addr %h", tag, w, addr_of(w));
            seq[w]++;
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor, sampling mid-cycle after stimulus has settled.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (m_rvalid !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("rvalid with no expectation", 32'(m_rvalid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp owner", 32'(m_rvalid), 32'(e[33:32]));
                    check("resp data", m_rdata, e[31:0]);
                    $display("[TB] response rvalid=%b rdata=%h", m_rvalid, m_rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        seq[0] = 0; seq[1] = 0;
        rst_n = 1'b0; m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        drive_fields();
        @(negedge clk); @(negedge clk);
        #1;
        check("reset s_req", 32'(s_req), 32'h0);
        check("reset gnt", 32'(m_gnt), 32'h0);
        check("reset rvalid", 32'(m_rvalid), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset rdata passthru", m_rdata, 32'h1234_5678);
        @(negedge clk);
        rst_n = 1'b1; s_rvalid = 1'b0;

        // Round-robin with one-cycle response latency
        cyc("rr0", 2'b11, 1'b1, 1'b0, 2'b01, 1'b1);
        cyc("rr1", 2'b11, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc("rr2", 2'b11, 1'b1, 1'b1, 2'b01, 1'b1);
        cyc("rr3", 2'b11, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc("rr4", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);

        // Single requester keeps returning ptr to 0
        cyc("single0", 2'b10, 1'b1, 1'b0, 2'b10, 1'b1);
        cyc("single1", 2'b10, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc("single2", 2'b10, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc("single3", 2'b11, 1'b1, 1'b1, 2'b01, 1'b1);
        cyc("single4", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);

        // Backpressure from the slave
        cyc("bp0", 2'b01, 1'b0, 1'b0, 2'b00, 1'b1);
        cyc("bp1", 2'b01, 1'b0, 1'b0, 2'b00, 1'b1);
        cyc("bp2", 2'b01, 1'b0, 1'b0, 2'b00, 1'b1);
        cyc("bp3", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        cyc("bp4", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("bp5", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);

        // Owner FIFO full, then push+pop in the same cycle
        cyc("full0", 2'b11, 1'b1, 1'b0, 2'b10, 1'b1);
        cyc("full1", 2'b11, 1'b1, 1'b0, 2'b01, 1'b1);
        cyc("full2", 2'b11, 1'b1, 1'b0, 2'b00, 1'b0);
        cyc("full3", 2'b11, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc("full4", 2'b01, 1'b1, 1'b1, 2'b01, 1'b1);
        cyc("full5", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc("full6", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        check("err before spurious", 32'(err), 32'h0);

        // Spurious response with empty FIFO
        cyc("spur0", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        check("err after spurious", 32'(err), 32'h1);
        cyc("spur1", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("spur2", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        check("err sticky", 32'(err), 32'h1);
        rst_n = 1'b0;
        #1;
        check("err cleared by reset", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-operation discards the outstanding transfer
        cyc("mid0", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        rst_n = 1'b0;
        ram_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("mid1", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        check("err after post-reset rvalid", 32'(err), 32'h1);

        @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
